// File: rtl/serial_byte_loader_pkg.sv
// loader_pkg: shared state encoding, defaults and parity helper for the serial byte loader
package loader_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOAD} loader_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A set result means the received parity bit does not match the word.
    function automatic logic parity_fail(input logic word_xor, input logic par, input logic odd);
        return word_xor ^ par ^ odd;
    endfunction

endpackage

// File: rtl/serial_byte_loader_if.sv
// serial_byte_loader_if: serial input stream plus parallel load/status outputs of the loader
interface serial_byte_loader_if
    import loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sin_valid;
    logic             sin_bit;
    logic [WIDTH-1:0] data;
    logic             enable;
    logic             parity_err;
    logic             frame_abort;
    logic             busy;

    modport master (
        output start, sin_valid, sin_bit,
        input  data, enable, parity_err, frame_abort, busy
    );

    modport slave (
        input  start, sin_valid, sin_bit,
        output data, enable, parity_err, frame_abort, busy
    );
endinterface

// File: rtl/serial_byte_loader.sv
// serial_byte_loader: shifts a MSB-first bit stream into a word, optionally checks parity, pulses enable to load it
module serial_byte_loader
    import loader_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    serial_byte_loader_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    loader_state_t    state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n, data_q, data_n;
    logic [CW-1:0]    count, count_n;
    logic             abort_q, abort_n, perr_q, perr_n;
    logic             bad_parity;

    assign bad_parity = parity_fail(^shift_reg, bus.sin_bit, ODD_PARITY);

    // Next-state decode; start while a frame is in flight restarts it, start during LOAD chains the next frame.
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        count_n = count;
        abort_n = 1'b0;
        perr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = SHIFT;
                    count_n = '0;
                end
            end
            SHIFT, PARITY: begin
                if (bus.start) begin
                    abort_n = 1'b1;
                    count_n = '0;
                    state_n = SHIFT;
                end else if (bus.sin_valid && state == SHIFT) begin
                    shift_n = {shift_reg[WIDTH-2:0], bus.sin_bit};
                    count_n = count + 1'b1;
                    if (count_n == CW'(WIDTH))
                        state_n = PARITY_EN ? PARITY : LOAD;
                end else if (bus.sin_valid) begin
                    perr_n  = bad_parity;
                    state_n = bad_parity ? IDLE : LOAD;
                end
            end
            LOAD: begin
                state_n = bus.start ? SHIFT : IDLE;
                count_n = bus.start ? '0 : count;
            end
            default: state_n = IDLE;
        endcase
        data_n = (state_n == LOAD) ? shift_n : data_q;
    end

    // State and datapath registers; data only changes on the edge that enters LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            data_q    <= '0;
            abort_q   <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            count     <= count_n;
            data_q    <= data_n;
            abort_q   <= abort_n;
            perr_q    <= perr_n;
        end
    end

    assign bus.data        = data_q;
    assign bus.enable      = (state == LOAD);
    assign bus.parity_err  = perr_q;
    assign bus.frame_abort = abort_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_serial_byte_loader.sv
// tb_serial_byte_loader: directed checks of the loader feeding an enable-loaded register
module tb_serial_byte_loader;
    import loader_pkg::*;

    typedef struct {
        logic [7:0] word;
        logic       par;
        logic       exp_en;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] reg_q;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         en_cnt = 0, perr_cnt = 0, abort_cnt = 0, excl_err = 0, busy_drop = 0;
    logic       prev_en = 1'b0, prev_perr = 1'b0, prev_abort = 1'b0;
    vec_t       vecs[8];

    serial_byte_loader_if #(.WIDTH(8)) bus ();
    serial_byte_loader_if #(.WIDTH(8)) bus2 ();

    serial_byte_loader #(.WIDTH(8), .PARITY_EN(1'b1), .ODD_PARITY(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_byte_loader #(.WIDTH(8), .PARITY_EN(1'b0), .ODD_PARITY(1'b1)) dut_np (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Downstream enable-loaded register fed directly by the loader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) reg_q <= '0;
        else if (bus.enable) reg_q <= bus.data;
    end

    // Pulse counting and exclusivity/one-cycle watch on the parity build.
    always @(negedge clk) begin
        if (!rst) begin
            if (32'(bus.enable) + 32'(bus.parity_err) + 32'(bus.frame_abort) > 1) excl_err++;
            if ((bus.enable && prev_en) || (bus.parity_err && prev_perr) || (bus.frame_abort && prev_abort)) excl_err++;
            en_cnt    += 32'(bus.enable);
            perr_cnt  += 32'(bus.parity_err);
            abort_cnt += 32'(bus.frame_abort);
        end
        prev_en    = bus.enable;
        prev_perr  = bus.parity_err;
        prev_abort = bus.frame_abort;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_bits(input logic [7:0] w, input int gap, input logic par);
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                bus.sin_valid = 1'b0;
                tick();
                if (!bus.busy) busy_drop++;
            end
            bus.sin_valid = 1'b1;
            bus.sin_bit   = w[i];
            tick();
        end
        bus.sin_valid = 1'b1;
        bus.sin_bit   = par;
        tick();
        bus.sin_valid = 1'b0;
    endtask

    task automatic send_start();
        bus.start     = 1'b1;
        bus.sin_valid = 1'b1;
        bus.sin_bit   = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        int en0, ab0;
        bus.start = 0; bus.sin_valid = 0; bus.sin_bit = 0;
        bus2.start = 0; bus2.sin_valid = 0; bus2.sin_bit = 0;
        vecs[0] = '{8'hAA, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 8'h07};
        vecs[2] = '{8'h07, 1'b0, 1'b0, 1'b1, 8'h07};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'h80};
        vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00};

        repeat (3) tick();
        check("reset data", 32'(bus.data), 0);
        check("reset enable", 32'(bus.enable), 0);
        check("reset parity_err", 32'(bus.parity_err), 0);
        check("reset frame_abort", 32'(bus.frame_abort), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset reg", 32'(reg_q), 0);
        check("reset data np", 32'(bus2.data), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            send_start();
            check($sformatf("v%0d busy", k), 32'(bus.busy), 1);
            send_bits(vecs[k].word, 0, vecs[k].par);
            check($sformatf("v%0d enable", k), 32'(bus.enable), 32'(vecs[k].exp_en));
            check($sformatf("v%0d parity_err", k), 32'(bus.parity_err), 32'(vecs[k].exp_perr));
            check($sformatf("v%0d data", k), 32'(bus.data), 32'(vecs[k].exp_data));
            tick();
            check($sformatf("v%0d enable low", k), 32'(bus.enable | bus.parity_err), 0);
            check($sformatf("v%0d idle", k), 32'(bus.busy), 0);
            check($sformatf("v%0d reg", k), 32'(reg_q), 32'(vecs[k].exp_data));
        end

        en0 = en_cnt; ab0 = abort_cnt;
        send_start();
        for (int i = 7; i >= 4; i--) begin
            bus.sin_valid = 1'b1; bus.sin_bit = 1'(8'h55 >> i); tick();
        end
        bus.sin_valid = 1'b0;
        send_start();
        check("abort pulse", 32'(bus.frame_abort), 1);
        check("abort no enable", 32'(bus.enable), 0);
        check("abort busy", 32'(bus.busy), 1);
        send_bits(8'hAA, 0, 1'b0);
        check("abort frame enable", 32'(bus.enable), 1);
        check("abort frame data", 32'(bus.data), 32'h AA);
        tick();
        check("abort enable count", 32'(en_cnt - en0), 1);
        check("abort count", 32'(abort_cnt - ab0), 1);

        en0 = en_cnt; busy_drop = 0;
        send_start();
        send_bits(8'h55, 3, 1'b0);
        check("gap enable", 32'(bus.enable), 1);
        check("gap data", 32'(bus.data), 32'h55);
        tick();
        check("gap busy held", 32'(busy_drop), 0);
        check("gap single enable", 32'(en_cnt - en0), 1);
        check("gap reg", 32'(reg_q), 32'h55);

        en0 = en_cnt; ab0 = abort_cnt;
        send_bits(8'h3C, 0, 1'b0);
        send_start();
        bus.start = 1'b1;
        check("chain enable", 32'(bus.enable), 0);
        send_start();
        bus.start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus.sin_valid = 1'b1; bus.sin_bit = 1'(8'hC3 >> i); tick();
        end
        bus.sin_valid = 1'b1; bus.sin_bit = 1'b0; tick();
        bus.sin_valid = 1'b0;
        check("chain first load data", 32'(bus.data), 32'hC3);
        check("chain first enable", 32'(bus.enable), 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("load+start no abort", 32'(bus.frame_abort), 0);
        check("load+start busy", 32'(bus.busy), 1);
        check("load+start reg", 32'(reg_q), 32'hC3);
        send_bits(8'h18, 0, 1'b0);
        check("chained data", 32'(bus.data), 32'h18);
        check("chained enable", 32'(bus.enable), 1);
        tick();
        check("chain abort count", 32'(abort_cnt - ab0), 1);

        en0 = en_cnt;
        send_start();
        for (int i = 7; i >= 3; i--) begin
            bus.sin_valid = 1'b1; bus.sin_bit = 1'(8'hF0 >> i); tick();
        end
        bus.sin_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst data", 32'(bus.data), 0);
        check("async rst busy", 32'(bus.busy), 0);
        check("async rst reg", 32'(reg_q), 0);
        #2 rst = 1'b0;
        tick();
        check("async rst no enable", 32'(en_cnt - en0), 0);
        send_start();
        send_bits(8'h3C, 0, 1'b0);
        check("post rst data", 32'(bus.data), 32'h3C);
        tick();
        check("post rst reg", 32'(reg_q), 32'h3C);

        bus2.start = 1'b1; tick(); bus2.start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus2.sin_valid = 1'b1; bus2.sin_bit = 1'b1; tick();
            if (i == 1) check("np early enable", 32'(bus2.enable), 0);
        end
        bus2.sin_valid = 1'b0;
        check("np enable", 32'(bus2.enable), 1);
        check("np data", 32'(bus2.data), 32'hFF);
        tick();
        check("np idle", 32'(bus2.enable | bus2.busy), 0);

        check("pulse exclusivity", 32'(excl_err), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
